hazard_ctrl_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 51 +++++
 rtl/hazard_src_match.sv | 37 +++
 rtl/hazard_ctrl_unit.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types and constants for the ID-stage hazard control unit.
//             Holds the stall FSM state encoding, the default register
//             address width, and the packed bundle of pipeline control
//             outputs with its fixed encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   localparam int REG_ADDR_W_DEF = 5;

   typedef enum logic [0:0] {
      HZ_IDLE     = 1'b0,
      HZ_LU_STALL = 1'b1
   } hz_state_e;

   // Pipeline control bundle driven to the IF and ID stages.
   typedef struct packed {
      logic pc_write_en;
      logic ifid_write;
      logic ifid_flush;
      logic idex_flush;
      logic pipe_freeze;
   } hz_ctrl_t;

   // Normal flow: fetch advances, nothing squashed.
   localparam hz_ctrl_t HZ_CTRL_NORMAL = '{pc_write_en: 1'b1, ifid_write: 1'b1,
                                          ifid_flush: 1'b0, idex_flush: 1'b0,
                                          pipe_freeze: 1'b0};
   // Load-use bubble: hold PC and IF/ID, inject a bubble into ID/EX.
   localparam hz_ctrl_t HZ_CTRL_STALL  = '{pc_write_en: 1'b0, ifid_write: 1'b0,
                                          ifid_flush: 1'b0, idex_flush: 1'b1,
                                          pipe_freeze: 1'b0};
   // Taken branch: redirect PC and squash the two younger instructions.
   localparam hz_ctrl_t HZ_CTRL_FLUSH  = '{pc_write_en: 1'b1, ifid_write: 1'b1,
                                          ifid_flush: 1'b1, idex_flush: 1'b1,
                                          pipe_freeze: 1'b0};
   // Memory wait: everything holds.
   localparam hz_ctrl_t HZ_CTRL_FREEZE = '{pc_write_en: 1'b0, ifid_write: 1'b0,
                                          ifid_flush: 1'b0, idex_flush: 1'b0,
                                          pipe_freeze: 1'b1};
   // Values presented while reset is asserted.
   localparam hz_ctrl_t HZ_CTRL_RESET  = '{pc_write_en: 1'b0, ifid_write: 1'b0,
                                          ifid_flush: 1'b1, idex_flush: 1'b1,
                                          pipe_freeze: 1'b0};

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_src_match.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_src_match
//  Purpose  : Compares one destination register against NUM_SRC ID-stage
//             source addresses. A source only counts when its used bit is
//             set, and register x0 never matches.
//  Ports    : rd      - destination address to compare against
//             rs      - packed sources, src i at [i*REG_ADDR_W +: REG_ADDR_W]
//             rs_used - per-source valid mask
//             hit     - 1 when any used source equals a non-zero rd
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_src_match
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int NUM_SRC    = 2
) (
   input  logic [REG_ADDR_W-1:0]         rd,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs,
   input  logic [NUM_SRC-1:0]            rs_used,
   output logic                          hit
);

   logic [NUM_SRC-1:0] src_hit;
   logic               rd_nonzero;

   assign rd_nonzero = |rd;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign src_hit[i] = rs_used[i] && (rs[i*REG_ADDR_W +: REG_ADDR_W] == rd);
   end

   assign hit = rd_nonzero && (|src_hit);

endmodule : hazard_src_match
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_unit
//  Purpose  : ID-stage hazard controller for the 5-stage RV32 pipeline.
//             Detects load-use hazards and inserts LOAD_LAT bubbles through
//             a small stall FSM, flushes on taken branches/jumps and freezes
//             the pipeline while instruction or data memory is waiting.
//             Priority: freeze > branch flush > load-use stall > normal.
//             Control outputs are combinational from state and inputs.
//  Ports    : clk, rst (asynchronous, active-low)
//             id_rs, id_rs_used           - ID-stage sources and valid mask
//             exe_mem_read, exe_rd        - load in EXE and its destination
//             branch_taken                - EXE resolved a taken branch/jump
//             im_stall, dm_stall          - memory not ready
//             pc_write_en, ifid_write, ifid_flush, idex_flush, pipe_freeze
//  Option   : HAZARD_PERF_CNT_EN adds 32-bit counters stall_cycles,
//             flush_count and freeze_cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int NUM_SRC    = 2,
   parameter int LOAD_LAT   = 2,
   parameter int CNT_W      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
   input  logic [NUM_SRC-1:0]            id_rs_used,
   input  logic                          exe_mem_read,
   input  logic [REG_ADDR_W-1:0]         exe_rd,
   input  logic                          branch_taken,
   input  logic                          im_stall,
   input  logic                          dm_stall,
   output logic                          pc_write_en,
   output logic                          ifid_write,
   output logic                          ifid_flush,
   output logic                          idex_flush,
   output logic                          pipe_freeze
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]                   stall_cycles,
   output logic [31:0]                   flush_count,
   output logic [31:0]                   freeze_cycles
`endif
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic     src_hit;
   logic     lu_match;
   logic     freeze;
   logic     lu_bubble;
   logic     br_flush;
   hz_ctrl_t ctrl;

   hazard_src_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_SRC    (NUM_SRC)
   ) u_src_match (
      .rd      (exe_rd),
      .rs      (id_rs),
      .rs_used (id_rs_used),
      .hit     (src_hit)
   );

   assign lu_match = exe_mem_read && src_hit;
   assign freeze   = im_stall || dm_stall;

   // Next-state and control decode. Freeze holds the FSM; a branch that
   // arrives during a freeze is still held in EXE and is taken up on the
   // first unfrozen cycle without any stored bookkeeping.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl      = HZ_CTRL_NORMAL;
      lu_bubble = 1'b0;
      br_flush  = 1'b0;

      if (freeze) begin
         ctrl = HZ_CTRL_FREEZE;
      end else if (branch_taken) begin
         // The dependent instruction is squashed, so any pending stall is moot.
         ctrl     = HZ_CTRL_FLUSH;
         br_flush = 1'b1;
         state_d  = HZ_IDLE;
         cnt_d    = '0;
      end else if (state_q == HZ_LU_STALL) begin
         // EXE now holds a bubble; stall purely on the remaining count.
         ctrl      = HZ_CTRL_STALL;
         lu_bubble = 1'b1;
         if (cnt_q == CNT_ONE) begin
            state_d = HZ_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end else if (lu_match) begin
         ctrl      = HZ_CTRL_STALL;
         lu_bubble = 1'b1;
         if (LOAD_LAT > 1) begin
            state_d = HZ_LU_STALL;
            cnt_d   = CNT_INIT;
         end
      end

      // Reset overrides the outputs immediately, not on the next edge.
      if (!rst) begin
         ctrl = HZ_CTRL_RESET;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= HZ_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_write_en = ctrl.pc_write_en;
   assign ifid_write  = ctrl.ifid_write;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_flush  = ctrl.idex_flush;
   assign pipe_freeze = ctrl.pipe_freeze;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;
   logic [31:0] freeze_cycles_q, freeze_cycles_d;

   // Counters wrap naturally at 2**32.
   always_comb begin
      stall_cycles_d  = stall_cycles_q  + {31'd0, lu_bubble};
      flush_count_d   = flush_count_q   + {31'd0, br_flush};
      freeze_cycles_d = freeze_cycles_q + {31'd0, freeze};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q  <= '0;
         flush_count_q   <= '0;
         freeze_cycles_q <= '0;
      end else begin
         stall_cycles_q  <= stall_cycles_d;
         flush_count_q   <= flush_count_d;
         freeze_cycles_q <= freeze_cycles_d;
      end
   end

   assign stall_cycles  = stall_cycles_q;
   assign flush_count   = flush_count_q;
   assign freeze_cycles = freeze_cycles_q;
`endif

endmodule : hazard_ctrl_unit
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_unit
//  Purpose  : Directed self-checking bench for hazard_ctrl_unit with default
//             parameters (REG_ADDR_W=5, NUM_SRC=2, LOAD_LAT=2). Outputs are
//             compared as a 5-bit vector
//             {pc_write_en, ifid_write, ifid_flush, idex_flush, pipe_freeze}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

   localparam logic [4:0] E_NORM   = 5'b11000;
   localparam logic [4:0] E_STALL  = 5'b00010;
   localparam logic [4:0] E_FLUSH  = 5'b11110;
   localparam logic [4:0] E_FREEZE = 5'b00001;
   localparam logic [4:0] E_RESET  = 5'b00110;

   logic       clk;
   logic       rst;
   logic [9:0] id_rs;
   logic [1:0] id_rs_used;
   logic       exe_mem_read;
   logic [4:0] exe_rd;
   logic       branch_taken;
   logic       im_stall;
   logic       dm_stall;
   logic       pc_write_en;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idex_flush;
   logic       pipe_freeze;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
   logic [31:0] freeze_cycles;
`endif

   int n_chk;
   int n_pass;

   hazard_ctrl_unit u_dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs        (id_rs),
      .id_rs_used   (id_rs_used),
      .exe_mem_read (exe_mem_read),
      .exe_rd       (exe_rd),
      .branch_taken (branch_taken),
      .im_stall     (im_stall),
      .dm_stall     (dm_stall),
      .pc_write_en  (pc_write_en),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .pipe_freeze  (pipe_freeze)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count),
      .freeze_cycles(freeze_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] outs();
      return {pc_write_en, ifid_write, ifid_flush, idex_flush, pipe_freeze};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Check outputs mid-cycle, then advance past the next rising edge.
   task automatic cyc(input string tag, input logic [4:0] exp);
      @(negedge clk);
      chk(tag, {27'd0, outs()}, {27'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      id_rs        = '0;
      id_rs_used   = '0;
      exe_mem_read = 1'b0;
      exe_rd       = '0;
      branch_taken = 1'b0;
      im_stall     = 1'b0;
      dm_stall     = 1'b0;
   endtask

   // Load of x5 in EXE with ID consuming x5 on rs1.
   task automatic lw_x5_dep();
      id_rs        = {5'd0, 5'd5};
      id_rs_used   = 2'b01;
      exe_mem_read = 1'b1;
      exe_rd       = 5'd5;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      idle_in();
      rst = 1'b0;
      #2;
      chk("reset_outs", {27'd0, outs()}, {27'd0, E_RESET});
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Basic load-use: two bubbles then release.
      cyc("idle_norm", E_NORM);
      lw_x5_dep();
      cyc("lu_bubble1", E_STALL);
      idle_in();
      cyc("lu_bubble2", E_STALL);
      cyc("lu_release", E_NORM);

      // x0 never matches; unused source never matches.
      id_rs = '0; id_rs_used = 2'b01; exe_mem_read = 1'b1; exe_rd = 5'd0;
      cyc("x0_nomatch", E_NORM);
      id_rs = {5'd5, 5'd3}; id_rs_used = 2'b01; exe_rd = 5'd5;
      cyc("unused_rs2", E_NORM);
      id_rs_used = 2'b10;
      cyc("rs2_bubble1", E_STALL);
      idle_in();
      cyc("rs2_bubble2", E_STALL);
      cyc("rs2_release", E_NORM);
      // Matching register but not a load.
      id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01; exe_rd = 5'd7; exe_mem_read = 1'b0;
      cyc("no_load", E_NORM);

      // Branch aborts a stall.
      lw_x5_dep();
      cyc("br_bubble1", E_STALL);
      idle_in(); branch_taken = 1'b1;
      cyc("br_flush", E_FLUSH);
      idle_in();
      cyc("br_after", E_NORM);

      // Branch beats a simultaneous load-use match in IDLE.
      lw_x5_dep(); branch_taken = 1'b1;
      cyc("br_over_lu", E_FLUSH);
      idle_in();
      cyc("br_over_lu_after", E_NORM);

      // Freeze mid-stall holds the counter; exactly two bubbles overall.
      lw_x5_dep();
      cyc("dm_bubble1", E_STALL);
      idle_in(); dm_stall = 1'b1;
      for (int i = 0; i < 3; i++) cyc("dm_freeze", E_FREEZE);
      dm_stall = 1'b0;
      cyc("dm_bubble2", E_STALL);
      cyc("dm_release", E_NORM);

      // Branch during instruction-memory wait is taken once unfrozen.
      branch_taken = 1'b1; im_stall = 1'b1;
      cyc("im_freeze1", E_FREEZE);
      cyc("im_freeze2", E_FREEZE);
      im_stall = 1'b0;
      cyc("im_br_flush", E_FLUSH);
      idle_in();
      cyc("im_after", E_NORM);

      // Freeze beats a load-use match.
      lw_x5_dep(); im_stall = 1'b1;
      cyc("frz_over_lu", E_FREEZE);
      im_stall = 1'b0;
      cyc("lu_after_frz", E_STALL);
      idle_in();
      cyc("lu_after_frz2", E_STALL);
      cyc("lu_after_frz_rel", E_NORM);

      // Asynchronous reset in the middle of LU_STALL.
      lw_x5_dep();
      cyc("rst_bubble1", E_STALL);
      idle_in();
      rst = 1'b0;
      #1;
      chk("rst_async", {27'd0, outs()}, {27'd0, E_RESET});
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall0", stall_cycles, 32'd0);
      chk("perf_flush0", flush_count, 32'd0);
      chk("perf_freeze0", freeze_cycles, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc("rst_no_residual", E_NORM);

`ifdef HAZARD_PERF_CNT_EN
      // One bubble pair, one flush, two freezes.
      lw_x5_dep();
      cyc("pc_b1", E_STALL);
      idle_in();
      cyc("pc_b2", E_STALL);
      branch_taken = 1'b1;
      cyc("pc_fl", E_FLUSH);
      idle_in(); im_stall = 1'b1;
      cyc("pc_fz1", E_FREEZE);
      cyc("pc_fz2", E_FREEZE);
      idle_in();
      chk("perf_stall", stall_cycles, 32'd2);
      chk("perf_flush", flush_count, 32'd1);
      chk("perf_freeze", freeze_cycles, 32'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_hazard_ctrl_unit
`default_nettype wire
